seq_8: RTL and testbench
========================

// Module: seq_8
//
// PURPOSE
// - Programmable 8-bit serial sequence detector for the CAN controller datapath.
// - While load=1, din bits are shifted in to form the target pattern.
// - While load=0, din is compared against that pattern.
// - dout pulses high for one clock whenever the last 8 sampled bits equal the pattern.
//
// PARAMETERS
// - WIDTH      8      pattern and history length in bits (the spec values below assume 8)
// - RST_PAT    8'h00  pattern register value after reset
//
// PORTS
// - clk   in   1  system clock; all sampling on the rising edge
// - rst   in   1  asynchronous, active-low reset (0 = reset)
// - load  in   1  1 = shift din into the pattern register; 0 = detect mode
// - din   in   1  serial data bit, sampled every rising clk edge
// - dout  out  1  registered match pulse
//
// BEHAVIOUR
// - Reset (rst=0, asynchronous), all registers forced:
//   - pat=RST_PAT, hist=0, cnt=0, state=IDLE, dout=0.
// - State machine (registered):
//   - IDLE: no valid pattern; dout=0; din ignored. load=1 -> LOAD.
//   - LOAD: each edge pat <= {pat[6:0],din} (MSB first); hist, cnt cleared; dout=0.
//     - load=0 -> FILL.
//     - Fewer than 8 load bits: the unshifted old pattern bits stay in the upper positions.
//   - FILL: each edge hist <= {hist[6:0],din}; cnt++. When cnt reaches 8 -> DETECT.
//   - DETECT: hist keeps shifting each edge; cnt saturates at 8.
// - Output timing:
//   - dout <= (cnt_next==8) && (hist_next==pat).
//   - dout is high in the cycle directly after the edge that sampled the 8th matching bit.
//   - dout is exactly 1 cycle wide unless a match recurs on the next edge.
// - load=1 in any state -> LOAD on the next edge.
//   - Takes priority over detection; dout=0 on that edge; the partial history is discarded.
// - The first match is possible only after 8 bits sampled with load=0; no comparison while cnt<8.
// - rst asserted mid-operation: immediate return to reset values; the pattern is lost.
// - din/load must meet setup/hold to clk; no internal synchronizer.
//
// CONFIGURATION
// - Macro SEQ8_OVERLAP_EN.
//   - Defined: overlapping detection. hist and cnt are untouched after a match.
//     - Example: pattern 8'hAA on stream 1010101010 gives matches on bits 8 and 10.
//   - Undefined (default): non-overlapping. On a match, hist and cnt are cleared and the state returns to FILL.
//     - The next match needs 8 fresh bits.
//     - The same stream gives a single match on bit 8.
//
// TESTING
// 1. Reset: hold rst=0, toggle din/load -> dout=0, no state change; release rst -> IDLE.
// 2. Load and detect: load=1 for 8 cycles with din=1,0,1,1,0,0,1,0 (pat=8'hB2).
//    - Then load=0 and feed the same 8 bits.
//    - dout=1 for exactly 1 cycle after the 8th bit; dout=0 before.
// 3. Mismatch: after pat=8'hB2, feed 8'hB3 -> dout stays 0.
// 4. Overlap: pat=8'hAA, stream 1010101010.
//    - With SEQ8_OVERLAP_EN: 2 pulses (after bits 8 and 10).
//    - Without it: 1 pulse.
// 5. Reload mid-detection: feed 5 bits of the pattern, assert load for 8 cycles (pat=8'hFF).
//    - Then 8 ones -> pulse only after the 8th one.
// 6. Async reset mid-stream: assert rst=0 between edges -> dout drops immediately.
//    - Previous pattern is not detected afterwards (IDLE).

Source files
------------

// File: rtl/seq_8.sv
// seq_8: programmable serial sequence detector for the CAN controller datapath.
// Latency: dout rises on the clock edge that samples the WIDTH-th matching bit.
// No backpressure. Build option SEQ8_OVERLAP_EN selects overlapping matches (default: non-overlapping).
module seq_8 #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_PAT = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic din,
   output logic dout
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

   // IDLE: no pattern has been loaded since reset, so nothing is compared.
   // LOAD: the most recent edge shifted a pattern bit in.
   // FILL: collecting history bits; fewer than WIDTH valid bits so far.
   // DETECT: history is full; every new bit produces a comparison.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      FILL   = 2'd2,
      DETECT = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pat, pat_nxt;
   logic [WIDTH-1:0] hist, hist_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             dout_nxt;
   logic             match;

   // Next-state logic: load always wins, otherwise shift history and compare once it is full.
   always_comb begin
      state_nxt = state;
      pat_nxt   = pat;
      hist_nxt  = hist;
      cnt_nxt   = cnt;
      dout_nxt  = 1'b0;
      match     = 1'b0;

      if (load) begin
         // MSB-first shift; a short load leaves old pattern bits in the upper positions.
         pat_nxt   = {pat[WIDTH-2:0], din};
         hist_nxt  = '0;
         cnt_nxt   = '0;
         state_nxt = LOAD;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = IDLE;
            end
            LOAD, FILL, DETECT: begin
               hist_nxt  = {hist[WIDTH-2:0], din};
               cnt_nxt   = (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
               match     = (cnt_nxt == CNT_FULL) && (hist_nxt == pat);
               dout_nxt  = match;
               state_nxt = (cnt_nxt == CNT_FULL) ? DETECT : FILL;
`ifdef SEQ8_OVERLAP_EN
               // Overlapping: the history window keeps sliding after a match.
`else
               // Non-overlapping: a match consumes its bits, the next one needs a fresh window.
               if (match) begin
                  hist_nxt  = '0;
                  cnt_nxt   = '0;
                  state_nxt = FILL;
               end
`endif
            end
            default: begin
               state_nxt = IDLE;
               hist_nxt  = '0;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, pattern, history and the registered match pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pat   <= RST_PAT;
         hist  <= '0;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         state <= state_nxt;
         pat   <= pat_nxt;
         hist  <= hist_nxt;
         cnt   <= cnt_nxt;
         dout  <= dout_nxt;
      end
   end

endmodule

// File: tb/tb_seq_8.sv
// tb_seq_8: directed bench for seq_8 with a queue-based reference model.
// The model keeps the last bits seen since the latest load and flags a match when 8 are present.
// Each directed scenario also pins the model with hand-computed pulse positions and counts.
module tb_seq_8;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic load = 1'b0;
   logic din  = 1'b0;
   logic dout;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int p0;

   seq_8 dut (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .din  (din),
      .dout (dout)
   );

   always #5 clk = ~clk;

   // Reference model
   logic [7:0] m_pat     = 8'h00;
   logic       m_valid   = 1'b0;
   logic       exp_dout  = 1'b0;
   bit         m_q[$];

   function automatic logic [7:0] hist_word();
      logic [7:0] w;
      w = 8'h00;
      foreach (m_q[i]) w = {w[6:0], m_q[i]};
      return w;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pat    <= 8'h00;
         m_valid  <= 1'b0;
         exp_dout <= 1'b0;
         m_q.delete();
      end else if (load) begin
         m_pat    <= {m_pat[6:0], din};
         m_valid  <= 1'b1;
         exp_dout <= 1'b0;
         m_q.delete();
      end else if (m_valid) begin
         m_q.push_back(din);
         if (m_q.size() > 8) void'(m_q.pop_front());
         if (m_q.size() == 8 && hist_word() == m_pat) begin
            exp_dout <= 1'b1;
`ifndef SEQ8_OVERLAP_EN
            m_q.delete();
`endif
         end else begin
            exp_dout <= 1'b0;
         end
      end else begin
         exp_dout <= 1'b0;
      end
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: dout=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, sampled 1 unit after the edge.
   always @(posedge clk) begin
      #1;
      check_bit("model", dout, exp_dout);
      if (dout === 1'b1) pulses++;
   end

   // Drive one bit; returns 2 units after the edge that sampled it.
   task automatic step(input logic l, input logic d);
      @(negedge clk);
      load = l;
      din  = d;
      @(posedge clk);
      #2;
   endtask

   task automatic load_pat(input logic [7:0] p);
      for (int i = 7; i >= 0; i--) step(1'b1, p[i]);
   endtask

   task automatic feed8(input logic [7:0] p);
      for (int i = 7; i >= 0; i--) step(1'b0, p[i]);
   endtask

   logic [7:0] v;

   initial begin
      // 1. Reset held: inputs toggle, dout must stay low.
      for (int i = 0; i < 4; i++) begin
         step(i[0], ~i[0]);
         check_bit("t1_rst_hold", dout, 1'b0);
      end
      @(negedge clk);
      rst  = 1'b1;
      load = 1'b0;
      din  = 1'b0;
      // IDLE after reset: reset pattern is 00 but nothing is compared before a load.
      p0 = pulses;
      feed8(8'h00);
      step(1'b0, 1'b0);
      check_int("t1_idle_pulses", pulses - p0, 0);

      // 2. Load B2, then feed B2: pulse exactly after the 8th bit.
      load_pat(8'hB2);
      v = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
         step(1'b0, v[i]);
         check_bit("t2_bit", dout, (i == 0) ? 1'b1 : 1'b0);
      end
      step(1'b0, 1'b0);
      check_bit("t2_width", dout, 1'b0);

      // 3. Mismatch: B3 against pattern B2.
      load_pat(8'hB2);
      p0 = pulses;
      feed8(8'hB3);
      step(1'b0, 1'b0);
      check_int("t3_mismatch_pulses", pulses - p0, 0);

      // 4. Pattern AA on 1010101010.
      load_pat(8'hAA);
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
         if (i == 7) check_bit("t4_bit8", dout, 1'b1);
`ifdef SEQ8_OVERLAP_EN
         if (i == 9) check_bit("t4_bit10", dout, 1'b1);
`else
         if (i == 9) check_bit("t4_bit10", dout, 1'b0);
`endif
      end
`ifdef SEQ8_OVERLAP_EN
      check_int("t4_pulses", pulses - p0, 2);
`else
      check_int("t4_pulses", pulses - p0, 1);
`endif

      // 5. Reload mid-detection: 5 bits of B2, then load FF, then 8 ones.
      load_pat(8'hB2);
      p0 = pulses;
      v = 8'hB2;
      for (int i = 7; i >= 3; i--) step(1'b0, v[i]);
      load_pat(8'hFF);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1);
         check_bit("t5_one", dout, (i == 7) ? 1'b1 : 1'b0);
      end
      check_int("t5_pulses", pulses - p0, 1);

      // 6. Async reset while dout is high.
      load_pat(8'h3C);
      feed8(8'h3C);
      check_bit("t6_match", dout, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      check_bit("t6_async_drop", dout, 1'b0);
      step(1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      p0 = pulses;
      feed8(8'h3C);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check_int("t6_lost_pattern", pulses - p0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, limit 100000 time units");
      $fatal(1);
   end

endmodule
